jtcop_obj_scan: RTL and testbench

Per-line object table scanner for the Cop sprite pipeline. During each horizontal blank it walks the 256-entry object table and finds the sprites that intersect the next rendered line. For each hit it issues one 16-pixel tile draw request to the downstream object draw stage, using a single-pulse/busy handshake. It sits between the object table RAM and the draw stage, which fetches ROM data and fills the line buffer.

---
 rtl/jtcop_obj_scan.sv | 153 +++++++++++++++
 tb/tb_jtcop_obj_scan.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_scan.sv
// Per-line object table scanner: walks the 256-entry sprite table during
// horizontal blank and issues one tile draw request per sprite hitting vrender.
module jtcop_obj_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        LHBL,
  input  logic [8:0]  vrender,
  output logic [9:0]  tbl_addr,
  input  logic [15:0] tbl_dout,
  output logic        draw,
  input  logic        draw_busy,
  output logic [12:0] tile_id,
  output logic [3:0]  veff,
  output logic        hflip,
  output logic [3:0]  tile_pal,
  output logic [8:0]  hpos,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, RD0, CHK, RD1, RD2, ISSUE, HOLD, NEXT
  } state_t;

  state_t      st;
  logic        lhbl_l;
  logic        lhbl_fall;
  logic        hold_wait;
  logic [7:0]  idx;
  logic [8:0]  vline;

  logic        l_hflip;
  logic [3:0]  l_veff;
  logic [2:0]  l_row;
  logic [12:0] l_code;

  logic [8:0]  ydiff;
  logic [8:0]  height;
  logic [2:0]  row_mask;
  logic [2:0]  row_raw;
  logic [2:0]  row_n;
  logic [3:0]  veff_n;
  logic        hit;

  assign lhbl_fall = lhbl_l & ~LHBL;

  // w0 decode: full 9-bit modular difference so sprites wrapping below y=0 still hit
  always_comb begin
    ydiff  = vline - tbl_dout[8:0];
    height = 9'd16 << tbl_dout[12:11];
    case (tbl_dout[12:11])
      2'd0:    row_mask = 3'd0;
      2'd1:    row_mask = 3'd1;
      2'd2:    row_mask = 3'd3;
      default: row_mask = 3'd7;
    endcase
    hit     = tbl_dout[15] && (ydiff < height);
    row_raw = ydiff[6:4] & row_mask;
    row_n   = tbl_dout[14] ? (row_mask - row_raw) : row_raw;
    veff_n  = tbl_dout[14] ? ~ydiff[3:0] : ydiff[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      lhbl_l    <= 1'b0;
      hold_wait <= 1'b0;
      idx       <= '0;
      vline     <= '0;
      l_hflip   <= 1'b0;
      l_veff    <= '0;
      l_row     <= '0;
      l_code    <= '0;
      tbl_addr  <= '0;
      draw      <= 1'b0;
      tile_id   <= '0;
      veff      <= '0;
      hflip     <= 1'b0;
      tile_pal  <= '0;
      hpos      <= '0;
      done      <= 1'b0;
    end else begin
      lhbl_l <= LHBL;
      draw   <= 1'b0;
      // A new blank always wins, whatever the scan was doing
      if (lhbl_fall) begin
        idx       <= '0;
        done      <= 1'b0;
        vline     <= vrender;
        hold_wait <= 1'b0;
        st        <= RD0;
      end else begin
        case (st)
          IDLE: ;
          RD0: begin
            tbl_addr <= {idx, 2'd0};
            st       <= CHK;
          end
          CHK: begin
            if (hit) begin
              l_hflip  <= tbl_dout[13];
              l_veff   <= veff_n;
              l_row    <= row_n;
              tbl_addr <= {idx, 2'd1};
              st       <= RD1;
            end else begin
              st <= NEXT;
            end
          end
          RD1: begin
            l_code   <= tbl_dout[12:0];
            tbl_addr <= {idx, 2'd2};
            st       <= RD2;
          end
          // Visible fields are only updated here so they stay stable through the draw
          RD2: begin
            tile_id  <= l_code + {10'd0, l_row};
            veff     <= l_veff;
            hflip    <= l_hflip;
            tile_pal <= tbl_dout[15:12];
            hpos     <= tbl_dout[8:0];
            st       <= ISSUE;
          end
          ISSUE: begin
            if (!draw_busy) begin
              draw      <= 1'b1;
              hold_wait <= 1'b0;
              st        <= HOLD;
            end
          end
          // First HOLD cycle ignores busy: the draw stage has not raised it yet
          HOLD: begin
            if (!hold_wait) begin
              hold_wait <= 1'b1;
            end else if (!draw_busy) begin
              st <= NEXT;
            end
          end
          NEXT: begin
            if (idx == 8'hff) begin
              done <= 1'b1;
              st   <= IDLE;
            end else begin
              idx <= idx + 8'd1;
              st  <= RD0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtcop_obj_scan.sv
// Scoreboard bench for jtcop_obj_scan: directed sprite tables, expected draws
// queued up front and checked by a monitor whenever draw pulses.
module tb_jtcop_obj_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        LHBL;
  logic [8:0]  vrender;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_dout;
  logic        draw;
  logic        draw_busy;
  logic [12:0] tile_id;
  logic [3:0]  veff;
  logic        hflip;
  logic [3:0]  tile_pal;
  logic [8:0]  hpos;
  logic        done;

  jtcop_obj_scan dut (
    .clk      (clk),
    .rst      (rst),
    .LHBL     (LHBL),
    .vrender  (vrender),
    .tbl_addr (tbl_addr),
    .tbl_dout (tbl_dout),
    .draw     (draw),
    .draw_busy(draw_busy),
    .tile_id  (tile_id),
    .veff     (veff),
    .hflip    (hflip),
    .tile_pal (tile_pal),
    .hpos     (hpos),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  assign tbl_dout = mem[tbl_addr];

  typedef struct packed {
    logic [12:0] tile;
    logic [3:0]  veff;
    logic        hflip;
    logic [3:0]  pal;
    logic [8:0]  x;
  } exp_t;

  exp_t sb[$];
  int   draw_cyc[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   draws = 0;
  int   cyc = 0;
  int   busy_len = 2;
  int   bcnt = 0;
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic prev_draw = 1'b0;

  assign draw_busy = model_busy | force_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Draw stage model: busy rises the cycle after draw and lasts busy_len cycles
  always @(negedge clk) begin
    if (draw) bcnt = busy_len;
    if (bcnt > 0) begin
      model_busy = 1'b1;
      bcnt--;
    end else begin
      model_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (draw) begin
      exp_t e;
      draws++;
      draw_cyc.push_back(cyc);
      chk("draw_back_to_back", {31'd0, prev_draw}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_draw", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tile_id",  {19'd0, tile_id},  {19'd0, e.tile});
        chk("veff",     {28'd0, veff},     {28'd0, e.veff});
        chk("hflip",    {31'd0, hflip},    {31'd0, e.hflip});
        chk("tile_pal", {28'd0, tile_pal}, {28'd0, e.pal});
        chk("hpos",     {23'd0, hpos},     {23'd0, e.x});
      end
    end
    prev_draw = draw;
  end

  task automatic clear_tbl();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic set_spr(input int n, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2);
    mem[n*4]   = w0;
    mem[n*4+1] = w1;
    mem[n*4+2] = w2;
  endtask

  task automatic push_exp(input logic [12:0] t, input logic [3:0] v, input logic h,
                          input logic [3:0] p, input logic [8:0] x);
    exp_t e;
    e.tile = t; e.veff = v; e.hflip = h; e.pal = p; e.x = x;
    sb.push_back(e);
  endtask

  // Returns at the negedge following the clock that samples LHBL low
  task automatic start_scan(input logic [8:0] vr);
    @(negedge clk);
    vrender = vr;
    LHBL    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    LHBL    = 1'b1;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    for (int i = 1; i <= 20000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk({nm, "_timeout"}, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    rst     = 1'b1;
    LHBL    = 1'b1;
    vrender = '0;
    clear_tbl();
    repeat (3) @(negedge clk);
    chk("rst_draw",     {31'd0, draw},     32'd0);
    chk("rst_tbl_addr", {22'd0, tbl_addr}, 32'd0);
    chk("rst_tile_id",  {19'd0, tile_id},  32'd0);
    chk("rst_veff",     {28'd0, veff},     32'd0);
    chk("rst_hflip",    {31'd0, hflip},    32'd0);
    chk("rst_tile_pal", {28'd0, tile_pal}, 32'd0);
    chk("rst_hpos",     {23'd0, hpos},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Empty table: exact scan length
    d0 = draws;
    start_scan(9'd100);
    chk("empty_done_cleared", {31'd0, done}, 32'd0);
    wait_done("empty", n);
    chk("empty_scan_clks", n, 32'd768);
    chk("empty_no_draw", draws - d0, 32'd0);

    // Single sprite plus height boundary neighbours
    clear_tbl();
    set_spr(5, 16'h8060, 16'h0123, 16'h3028);
    set_spr(6, 16'h0060, 16'h0777, 16'h5005);
    set_spr(7, 16'h8054, 16'h0333, 16'h2002);
    set_spr(8, 16'h8055, 16'h0200, 16'h0000);
    push_exp(13'h0123, 4'd4, 1'b0, 4'd3, 9'd40);
    push_exp(13'h0200, 4'd15, 1'b0, 4'd0, 9'd0);
    d0 = draws;
    start_scan(9'd100);
    wait_done("single", n);
    chk("single_draws", draws - d0, 32'd2);
    chk("single_sb_empty", sb.size(), 32'd0);

    // Tall vflip sprite at the first index
    clear_tbl();
    set_spr(0, 16'hD000, 16'h0100, 16'h712C);
    push_exp(13'h0102, 4'd11, 1'b0, 4'd7, 9'd300);
    start_scan(9'd20);
    wait_done("vflip", n);
    chk("vflip_sb_empty", sb.size(), 32'd0);

    // Wrap below y=0, last index, code wrap, hflip
    clear_tbl();
    set_spr(255, 16'hA9F4, 16'h1FFF, 16'hF1FF);
    push_exp(13'h0000, 4'd6, 1'b1, 4'hF, 9'd511);
    start_scan(9'd10);
    wait_done("wrap", n);
    chk("wrap_sb_empty", sb.size(), 32'd0);

    // Handshake: long busy between two adjacent hits
    clear_tbl();
    busy_len = 40;
    set_spr(10, 16'h80C8, 16'h0010, 16'h400A);
    set_spr(11, 16'h80C8, 16'h0020, 16'h400B);
    push_exp(13'h0010, 4'd5, 1'b0, 4'd4, 9'd10);
    push_exp(13'h0020, 4'd5, 1'b0, 4'd4, 9'd11);
    draw_cyc.delete();
    start_scan(9'd205);
    wait_done("handshake", n);
    chk("handshake_draws", draw_cyc.size(), 32'd2);
    if (draw_cyc.size() == 2)
      chk("handshake_gap", draw_cyc[1] - draw_cyc[0], 32'd47);
    chk("handshake_sb_empty", sb.size(), 32'd0);
    busy_len = 2;

    // Restart mid-scan at index 100
    clear_tbl();
    set_spr(50,  16'h812C, 16'h0050, 16'h2032);
    set_spr(150, 16'h812C, 16'h0150, 16'h2096);
    push_exp(13'h0050, 4'd2, 1'b0, 4'd2, 9'd50);
    push_exp(13'h0050, 4'd5, 1'b0, 4'd2, 9'd50);
    push_exp(13'h0150, 4'd5, 1'b0, 4'd2, 9'd150);
    d0 = draws;
    start_scan(9'd302);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tbl_addr[9:2] == 8'd100) begin
        n = 1;
        break;
      end
    end
    chk("restart_reached_100", n, 32'd1);
    start_scan(9'd305);
    @(posedge clk);
    #1;
    chk("restart_addr_zero", {22'd0, tbl_addr}, 32'd0);
    wait_done("restart", n);
    chk("restart_draws", draws - d0, 32'd3);
    chk("restart_sb_empty", sb.size(), 32'd0);

    // Reset while stalled in ISSUE
    clear_tbl();
    set_spr(0, 16'h8032, 16'h00AA, 16'h1007);
    force_busy = 1'b1;
    d0 = draws;
    start_scan(9'd55);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_draw",     {31'd0, draw},     32'd0);
    chk("midrst_tile_id",  {19'd0, tile_id},  32'd0);
    chk("midrst_tbl_addr", {22'd0, tbl_addr}, 32'd0);
    chk("midrst_done",     {31'd0, done},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    force_busy = 1'b0;
    repeat (1000) @(negedge clk);
    chk("midrst_no_draw", draws - d0, 32'd0);
    push_exp(13'h00AA, 4'd5, 1'b0, 4'd1, 9'd7);
    start_scan(9'd55);
    wait_done("after_rst", n);
    chk("after_rst_draws", draws - d0, 32'd1);
    chk("after_rst_sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
